// File: rtl/keypad_ebcd_encoder_if.sv
// Pin and output bundle between the keypad matrix, the encoder and the
// calculator input stage.
//
// Transfer protocol: eBCD[4] acts as a valid-only strobe (the receiver has no
// ready). eBCD[3:0] is loaded one cycle before eBCD[4] rises. It stays
// unchanged while eBCD[4] is high and after it falls. The receiver captures
// eBCD[3:0] on the rising edge of eBCD[4].
interface keypad_ebcd_encoder_if;
    logic [3:0] row_in;     // matrix rows, active-low, asynchronous
    logic [3:0] col_out;    // column drive, active-low, one-hot low
    logic [4:0] eBCD;       // [4] strobe, [3:0] key code
    logic       key_held;   // debounced key held
    logic       multi_key;  // one-cycle pulse per multi-key sweep
    logic [2:0] fsm_state;  // encoder FSM state, debug visibility

    // master: the encoder. slave: keypad pins plus the calculator input stage.
    modport master (input row_in, output col_out, eBCD, key_held, multi_key, fsm_state);
    modport slave  (output row_in, input col_out, eBCD, key_held, multi_key, fsm_state);
endinterface

// File: rtl/keypad_ebcd_encoder.sv
// 4x4 keypad scanner with sweep-level debounce. Emits one strobed 5-bit eBCD
// code per accepted key press.
module keypad_ebcd_encoder #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 5,
    parameter int STROBE_LEN     = 4
) (
    input  logic                  sw_clk,
    input  logic                  rst,
    keypad_ebcd_encoder_if.master bus
);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam int SW = $clog2(STROBE_LEN + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DB_TARGET  = CW'(DEBOUNCE_SCANS);
    localparam logic [SW-1:0] STB_LAST   = SW'(STROBE_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_PRESS_DB   = 3'd1,
        S_EMIT_SETUP = 3'd2,
        S_EMIT_HIGH  = 3'd3,
        S_HELD       = 3'd4,
        S_RELEASE_DB = 3'd5
    } state_t;

    // Matrix position (row*4+col) to key code. Code D is reserved and never strobed.
    function automatic logic [3:0] key_map(input logic [3:0] idx);
        case (idx)
            4'd0:    return 4'h1;
            4'd1:    return 4'h2;
            4'd2:    return 4'h3;
            4'd3:    return 4'hA;
            4'd4:    return 4'h4;
            4'd5:    return 4'h5;
            4'd6:    return 4'h6;
            4'd7:    return 4'hB;
            4'd8:    return 4'h7;
            4'd9:    return 4'h8;
            4'd10:   return 4'h9;
            4'd11:   return 4'hC;
            4'd12:   return 4'hE;
            4'd13:   return 4'h0;
            4'd14:   return 4'hF;
            default: return 4'hD;
        endcase
    endfunction

    logic [3:0]    row_s1_q, row_s2_q;
    logic [DW-1:0] dwell_q;
    logic [1:0]    col_idx_q;
    logic [3:0]    col_out_q;
    logic [15:0]   sweep_q;

    state_t        state_q, state_d;
    logic [3:0]    cand_q, cand_d;
    logic [CW-1:0] db_cnt_q, db_cnt_d;
    logic [SW-1:0] stb_cnt_q, stb_cnt_d;
    logic [3:0]    code_q, code_d;
    logic          strobe_q, strobe_d;
    logic          held_q, held_d;
    logic          multi_q, multi_d;

    logic          last_dwell, eval;
    logic [1:0]    col_nxt;
    logic [15:0]   sweep_now;
    logic [4:0]    n_pressed;
    logic [3:0]    hit_idx;
    logic          sweep_key, sweep_none;

    // Scan timing and the pressed-key map for the sweep in progress. The current column is merged in live.
    always_comb begin
        last_dwell = (dwell_q == DWELL_LAST);
        eval       = last_dwell && (col_idx_q == 2'd3);
        col_nxt    = col_idx_q + 2'd1;
        sweep_now  = sweep_q;
        for (int r = 0; r < 4; r++) begin
            sweep_now[{2'(r), col_idx_q}] = ~row_s2_q[r];
        end
    end

    // Classify the completed sweep as NONE / single KEY / multiple keys.
    always_comb begin
        n_pressed = '0;
        hit_idx   = '0;
        for (int i = 0; i < 16; i++) begin
            if (sweep_now[i]) begin
                n_pressed = n_pressed + 5'd1;
                hit_idx   = 4'(i);
            end
        end
        sweep_key  = eval && (n_pressed == 5'd1);
        sweep_none = eval && (n_pressed != 5'd1);
    end

    // Row synchroniser, column dwell counter and per-column row sampling. These never stop.
    always_ff @(posedge sw_clk or negedge rst) begin
        if (!rst) begin
            row_s1_q  <= 4'hF;
            row_s2_q  <= 4'hF;
            dwell_q   <= '0;
            col_idx_q <= '0;
            col_out_q <= 4'b1110;
            sweep_q   <= '0;
        end else begin
            row_s1_q <= bus.row_in;
            row_s2_q <= row_s1_q;
            if (last_dwell) begin
                dwell_q   <= '0;
                col_idx_q <= col_nxt;
                col_out_q <= ~(4'b0001 << col_nxt);
                sweep_q   <= sweep_now;
            end else begin
                dwell_q <= dwell_q + DW'(1);
            end
        end
    end

    // FSM state, candidate key and counters.
    always_ff @(posedge sw_clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cand_q    <= '0;
            db_cnt_q  <= '0;
            stb_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            db_cnt_q  <= db_cnt_d;
            stb_cnt_q <= stb_cnt_d;
        end
    end

    // Next-state logic. Sweep results that land during EMIT_SETUP or EMIT_HIGH are ignored.
    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        db_cnt_d  = db_cnt_q;
        stb_cnt_d = stb_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (sweep_key) begin
                    cand_d   = hit_idx;
                    db_cnt_d = CW'(1);
                    state_d  = (DB_TARGET == CW'(1)) ? S_EMIT_SETUP : S_PRESS_DB;
                end
            end
            S_PRESS_DB: begin
                if (sweep_key && (hit_idx == cand_q)) begin
                    db_cnt_d = db_cnt_q + CW'(1);
                    if (db_cnt_d == DB_TARGET) state_d = S_EMIT_SETUP;
                end else if (eval) begin
                    db_cnt_d = '0;
                    state_d  = S_IDLE;
                end
            end
            S_EMIT_SETUP: begin
                stb_cnt_d = '0;
                state_d   = (key_map(cand_q) == 4'hD) ? S_HELD : S_EMIT_HIGH;
            end
            S_EMIT_HIGH: begin
                if (stb_cnt_q == STB_LAST) state_d = S_HELD;
                else stb_cnt_d = stb_cnt_q + SW'(1);
            end
            S_HELD: begin
                if (sweep_none) begin
                    if (DB_TARGET == CW'(1)) begin
                        db_cnt_d = '0;
                        state_d  = S_IDLE;
                    end else begin
                        db_cnt_d = CW'(1);
                        state_d  = S_RELEASE_DB;
                    end
                end
            end
            S_RELEASE_DB: begin
                if (sweep_none) begin
                    db_cnt_d = db_cnt_q + CW'(1);
                    if (db_cnt_d == DB_TARGET) begin
                        db_cnt_d = '0;
                        state_d  = S_IDLE;
                    end
                end else if (sweep_key) begin
                    state_d = S_HELD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output next values, derived from the next state so that every output leaves a flop.
    // The code register is loaded on entry to EMIT_SETUP, one cycle ahead of the strobe.
    always_comb begin
        code_d = code_q;
        if ((state_d == S_EMIT_SETUP) && (key_map(cand_d) != 4'hD)) code_d = key_map(cand_d);
        strobe_d = (state_d == S_EMIT_HIGH);
        held_d   = (state_d == S_HELD) || (state_d == S_RELEASE_DB);
        multi_d  = eval && (n_pressed > 5'd1);
    end

    // Registered outputs. The asynchronous reset drops an in-progress strobe at once.
    always_ff @(posedge sw_clk or negedge rst) begin
        if (!rst) begin
            code_q   <= '0;
            strobe_q <= 1'b0;
            held_q   <= 1'b0;
            multi_q  <= 1'b0;
        end else begin
            code_q   <= code_d;
            strobe_q <= strobe_d;
            held_q   <= held_d;
            multi_q  <= multi_d;
        end
    end

    assign bus.col_out   = col_out_q;
    assign bus.eBCD      = {strobe_q, code_q};
    assign bus.key_held  = held_q;
    assign bus.multi_key = multi_q;
    assign bus.fsm_state = state_q;
endmodule
